// File: rtl/clz_unit.sv
// rtl/clz_unit.sv - iterative count-leading-zeros unit, one bit per cycle
// Operand is shifted left until its MSB is set or all 32 bits have been examined.
module clz_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] clz_data_in,
    output logic [31:0] clz_ans_out,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_sh,    w_sh_nxt;
    logic [5:0]  r_cnt,   w_cnt_nxt;
    logic [5:0]  r_ans,   w_ans_nxt;
    logic        r_busy,  w_busy_nxt;
    logic        w_done;

    assign clz_ans_out = {26'd0, r_ans};
    assign busy        = r_busy;

    // cnt stops at 32 so the all-zero operand terminates without wrapping
    assign w_done = r_sh[31] || (r_cnt == 6'd32);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_ans   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ans   <= w_ans_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_ans_nxt   = r_ans;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sh_nxt    = clz_data_in;
                    w_cnt_nxt   = 6'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_done) begin
                    w_ans_nxt   = r_cnt;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_sh_nxt  = {r_sh[30:0], 1'b0};
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_clz_unit.sv
// tb/tb_clz_unit.sv - self-checking bench for clz_unit with directed and random operands
module tb_clz_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] clz_data_in;
    logic [31:0] clz_ans_out;
    logic        busy;

    int          n_checks;
    int          n_errors;
    logic [31:0] model_ans;

    clz_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clz_data_in (clz_data_in),
        .clz_ans_out (clz_ans_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_clz(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 31 - i;
        end
        return 32;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation at the current negedge; returns at the negedge where busy is low again.
    // glitch_at > 0 pulses start with all-ones data during that busy cycle.
    task automatic do_op(input string tag, input logic [31:0] d, input bit hold, input int glitch_at);
        int cycles;
        int exp_n;
        exp_n       = ref_clz(d);
        start       = 1'b1;
        clz_data_in = d;
        @(negedge clk);
        chk({tag, "_busy_rise"}, busy, 1'b1);
        if (!hold) start = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            chk({tag, "_ans_hold"}, clz_ans_out, model_ans);
            clz_data_in = $urandom;
            if (glitch_at > 0 && cycles == glitch_at) begin
                start       = 1'b1;
                clz_data_in = 32'hFFFF_FFFF;
            end else if (glitch_at > 0 && cycles == glitch_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        model_ans = exp_n;
        chk({tag, "_busy_cycles"}, cycles, exp_n + 1);
        chk({tag, "_ans"}, clz_ans_out, model_ans);
    endtask

    initial begin
        int cyc;
        logic [31:0] d;
        n_checks    = 0;
        n_errors    = 0;
        model_ans   = 0;
        rst         = 1'b0;
        start       = 1'b1;
        clz_data_in = 32'h0000_00FF;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ans", clz_ans_out, 32'd0);

        // First start is taken on the very first edge with rst released
        rst = 1'b1;
        do_op("s22", 32'h00FF_FFFF, 1'b0, 0);
        do_op("s23", 32'h8000_0000, 1'b0, 0);
        do_op("s24", 32'h0000_0000, 1'b0, 0);
        do_op("s25", 32'h0000_0001, 1'b0, 5);
        chk("s25_value", clz_ans_out, 32'd31);

        // Abort during run: reset at the 5th busy cycle
        start       = 1'b1;
        clz_data_in = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 5) begin
            cyc++;
            @(negedge clk);
        end
        chk("s26_busy_mid", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        model_ans = 0;
        chk("s26_abort_busy", busy, 1'b0);
        chk("s26_abort_ans", clz_ans_out, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        do_op("s26_retry", 32'h0000_FFFF, 1'b0, 0);
        chk("s26_value", clz_ans_out, 32'd16);

        // start held high: second run is accepted one cycle after busy falls
        do_op("s27a", 32'h00FF_FFFF, 1'b1, 0);
        do_op("s27b", 32'h0FFF_FFFF, 1'b0, 0);
        chk("s27_value", clz_ans_out, 32'd4);

        for (int i = 0; i < 20; i++) begin
            d = $urandom >> $urandom_range(0, 32);
            do_op("rand", d, 1'b0, (i % 3 == 0) ? 1 : 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
